// File: rtl/sync_fifo_ram_ctrl_pkg.sv
// Shared helpers for the FWFT FIFO controller: pointer-width function and defaults.
package sync_fifo_ram_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  // ceil(log2(value)); used for pointer and counter widths
  function automatic int clogb2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_ram_ctrl_if.sv
// Producer/consumer handshake bundle of the FWFT FIFO; slave side is the FIFO.
interface sync_fifo_ram_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  import sync_fifo_ram_ctrl_pkg::*;

  localparam int CNT_W = clogb2(FIFO_DEPTH) + 1;

  logic                  flush_i;
  logic                  wr_valid_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  wr_ready_o;
  logic                  rd_valid_o;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic                  rd_ready_i;
  logic [CNT_W-1:0]      count_o;

  modport master (
    output flush_i, wr_valid_i, wr_data_i, rd_ready_i,
    input  wr_ready_o, rd_valid_o, rd_data_o, count_o
  );

  modport slave (
    input  flush_i, wr_valid_i, wr_data_i, rd_ready_i,
    output wr_ready_o, rd_valid_o, rd_data_o, count_o
  );

endinterface

// File: rtl/simple_dual_port_2_clock_ram.sv
// Simple dual-port RAM: write port A, registered read port B, independent clocks.
module simple_dual_port_2_clock_ram
  import sync_fifo_ram_ctrl_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter int   RAM_DEPTH  = 16,
  parameter       RAM_STYLE  = "distributed",
  parameter logic INIT_VAL   = 1'b0,
  parameter       SIMULATION = "FALSE"
) (
  input  logic                         clka_i,
  input  logic                         wra_i,
  input  logic [clogb2(RAM_DEPTH)-1:0] addra_i,
  input  logic [DATA_WIDTH-1:0]        dina_i,
  input  logic                         clkb_i,
  input  logic                         rdb_i,
  input  logic [clogb2(RAM_DEPTH)-1:0] addrb_i,
  output logic [DATA_WIDTH-1:0]        doutb_o
);

  localparam logic [DATA_WIDTH-1:0] FILL = {DATA_WIDTH{INIT_VAL}};
  // Block RAM read-during-write to the same address is undefined; flag it in simulation.
  localparam bit COLLIDE_FILL = (SIMULATION == "TRUE") && (RAM_STYLE == "block");

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] r_doutb;

  always_ff @(posedge clka_i) begin
    if (wra_i) r_mem[addra_i] <= dina_i;
  end

  always_ff @(posedge clkb_i) begin
    if (rdb_i) r_doutb <= (COLLIDE_FILL && wra_i && (addra_i == addrb_i)) ? FILL : r_mem[addrb_i];
  end

  assign doutb_o = r_doutb;

endmodule

// File: rtl/sync_fifo_ram_ctrl.sv
// FWFT FIFO controller around one simple dual-port RAM; head word lives in the RAM read register.
// SYNC_FIFO_LEVEL_EN enables the count_o level output; otherwise count_o is tied to 0.
module sync_fifo_ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter     RAM_STYLE  = "distributed"
) (
  input logic                clk_i,
  input logic                rst_i,
  sync_fifo_ram_ctrl_if.slave bus
);
  import sync_fifo_ram_ctrl_pkg::*;

  localparam int            AW       = clogb2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_ram_cnt;
  logic          r_rd_valid;

  logic w_clear;
  logic w_wr_ready;
  logic w_wr_en;
  logic w_pop;
  logic w_fetch;

  assign w_clear    = rst_i | bus.flush_i;
  assign w_wr_ready = (r_ram_cnt != FULL_CNT);
  assign w_wr_en    = bus.wr_valid_i & w_wr_ready & ~w_clear;
  assign w_pop      = r_rd_valid & bus.rd_ready_i & ~w_clear;
  // Refill the read register whenever it is empty or being consumed this cycle.
  assign w_fetch    = (r_ram_cnt != '0) & (~r_rd_valid | w_pop) & ~w_clear;

  always_ff @(posedge clk_i) begin
    if (w_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_fetch) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_en & ~w_fetch)      r_ram_cnt <= r_ram_cnt + 1'b1;
      else if (w_fetch & ~w_wr_en) r_ram_cnt <= r_ram_cnt - 1'b1;
      if (w_fetch)    r_rd_valid <= 1'b1;
      else if (w_pop) r_rd_valid <= 1'b0;
    end
  end

  assign bus.wr_ready_o = w_wr_ready;
  assign bus.rd_valid_o = r_rd_valid;

`ifdef SYNC_FIFO_LEVEL_EN
  assign bus.count_o = r_ram_cnt + {{AW{1'b0}}, r_rd_valid};
`else
  assign bus.count_o = '0;
`endif

  simple_dual_port_2_clock_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .RAM_DEPTH  (FIFO_DEPTH),
    .RAM_STYLE  (RAM_STYLE),
    .INIT_VAL   (1'bx),
    .SIMULATION ("TRUE")
  ) u_ram (
    .clka_i  (clk_i),
    .wra_i   (w_wr_en),
    .addra_i (r_wr_ptr),
    .dina_i  (bus.wr_data_i),
    .clkb_i  (clk_i),
    .rdb_i   (w_fetch),
    .addrb_i (r_rd_ptr),
    .doutb_o (bus.rd_data_o)
  );

endmodule

// File: tb/tb_sync_fifo_ram_ctrl.sv
// Bench for sync_fifo_ram_ctrl: vector table for first-word timing, scoreboard for streams, full, flush.
module tb_sync_fifo_ram_ctrl;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CAP   = DEPTH + 1;
`ifdef SYNC_FIFO_LEVEL_EN
  localparam bit LVL = 1'b1;
`else
  localparam bit LVL = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  sync_fifo_ram_ctrl_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  sync_fifo_ram_ctrl #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .RAM_STYLE  ("distributed")
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    bit          wv;
    logic [7:0]  wd;
    bit          rr;
    bit          e_rdy;
    bit          e_vld;
    logic [7:0]  e_dat;
    int          e_lvl;
  } vec_t;

  vec_t            tv [10];
  int              checks = 0;
  int              errors = 0;
  logic [DW-1:0]   q [$];
  bit              hold = 0;
  logic [DW-1:0]   hold_data = '0;
  bit              bub_en = 0;
  bit              seen = 0;
  int              npush = 0;
  int              npop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit fl);
    @(posedge clk_i);
    #1;
    bus.wr_valid_i = wv;
    bus.wr_data_i  = wd;
    bus.rd_ready_i = rr;
    bus.flush_i    = fl;
    #1;
  endtask

  // One cycle against the scoreboard; outputs sampled reflect words held before this cycle's edge.
  task automatic cyc(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit fl);
    drive(wv, wd, rr, fl);
    chk("wr_ready", bus.wr_ready_o, q.size() != CAP);
    chk("count", bus.count_o, LVL ? q.size() : 0);
    if (q.size() == 0) chk("empty_valid", bus.rd_valid_o, 0);
    else if (bus.rd_valid_o) chk("head_data", bus.rd_data_o, q[0]);
    if (hold) begin
      chk("hold_valid", bus.rd_valid_o, 1);
      chk("hold_data", bus.rd_data_o, hold_data);
    end
    if (bus.rd_valid_o) seen = 1;
    if (bub_en && seen) begin
      if (q.size() > 0) chk("bubble", bus.rd_valid_o, 1);
      chk("stream_level", bus.count_o <= 2, 1);
    end
    if (fl) begin
      q.delete();
      hold = 0;
    end else begin
      if (bus.rd_valid_o && rr && q.size() > 0) begin
        void'(q.pop_front());
        npop++;
      end
      if (wv && bus.wr_ready_o) begin
        q.push_back(wd);
        npush++;
      end
      hold      = bus.rd_valid_o && !rr;
      hold_data = bus.rd_data_o;
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 64 && q.size() > 0; k++) cyc(0, '0, 1, 0);
    chk(name, q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_valid_i = 0;
    bus.wr_data_i  = '0;
    bus.rd_ready_i = 0;
    bus.flush_i    = 0;

    tv[0] = '{1, 8'h11, 0, 1, 0, 8'h00, 0};
    tv[1] = '{1, 8'h12, 0, 1, 0, 8'h00, 1};
    tv[2] = '{1, 8'h13, 0, 1, 1, 8'h11, 2};
    tv[3] = '{1, 8'h14, 0, 1, 1, 8'h11, 3};
    tv[4] = '{0, 8'h00, 0, 1, 1, 8'h11, 4};
    tv[5] = '{0, 8'h00, 1, 1, 1, 8'h11, 4};
    tv[6] = '{0, 8'h00, 1, 1, 1, 8'h12, 3};
    tv[7] = '{0, 8'h00, 1, 1, 1, 8'h13, 2};
    tv[8] = '{0, 8'h00, 1, 1, 1, 8'h14, 1};
    tv[9] = '{0, 8'h00, 0, 1, 0, 8'h00, 0};

    repeat (3) @(posedge clk_i);
    #1 rst_i = 0;
    #1;
    chk("reset_rdy", bus.wr_ready_o, 1);
    chk("reset_vld", bus.rd_valid_o, 0);
    chk("reset_cnt", bus.count_o, 0);

    // first-word latency and in-order pop, one row per cycle
    for (int i = 0; i < 10; i++) begin
      drive(tv[i].wv, tv[i].wd, tv[i].rr, 0);
      chk($sformatf("tv%0d_rdy", i), bus.wr_ready_o, tv[i].e_rdy);
      chk($sformatf("tv%0d_vld", i), bus.rd_valid_o, tv[i].e_vld);
      if (tv[i].e_vld) chk($sformatf("tv%0d_dat", i), bus.rd_data_o, tv[i].e_dat);
      chk($sformatf("tv%0d_lvl", i), bus.count_o, LVL ? tv[i].e_lvl : 0);
    end

    // fill to capacity, then an ignored 18th write
    for (int i = 0; i < CAP; i++) cyc(1, DW'(8'h20 + i), 0, 0);
    cyc(1, 8'hEE, 0, 0);
    chk("full_rdy", bus.wr_ready_o, 0);
    chk("full_cnt", bus.count_o, LVL ? CAP : 0);
    chk("full_held", q.size(), CAP);
    drain("full_drain");

    // sustained one word per cycle
    npop   = 0;
    seen   = 0;
    bub_en = 1;
    for (int i = 0; i < 64; i++) cyc(1, DW'(i + 8'h40), 1, 0);
    drain("stream_drain");
    bub_en = 0;
    chk("stream_pops", npop, 64);

    // random back-pressure
    begin
      int n = 0;
      npush = 0;
      while ((npush < 1000 || q.size() > 0) && n < 6000) begin
        cyc((npush < 1000) && ($urandom_range(0, 99) < 80), DW'($urandom()),
            $urandom_range(0, 99) < 55, 0);
        n++;
      end
      chk("rand_pushes", npush, 1000);
      chk("rand_drained", q.size(), 0);
    end

    // flush with 5 held and a concurrent write
    for (int i = 0; i < 5; i++) cyc(1, DW'(8'h30 + i), 0, 0);
    cyc(1, 8'h77, 0, 1);
    cyc(0, '0, 0, 0);
    chk("flush_vld", bus.rd_valid_o, 0);
    chk("flush_cnt", bus.count_o, 0);
    chk("flush_rdy", bus.wr_ready_o, 1);
    cyc(1, 8'hA5, 0, 0);
    cyc(1, 8'h5A, 0, 0);
    cyc(0, '0, 0, 0);
    chk("flush_head_vld", bus.rd_valid_o, 1);
    chk("flush_head", bus.rd_data_o, 8'hA5);
    drain("flush_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
